// File: rtl/tnn_pkg.sv
// Shared types and elaboration helpers for the sequential TNN neuron.
package tnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Accumulator width: input width plus headroom for N_IN terms, plus a sign bit.
  function automatic int acc_width(input int n, input int w);
    return w + $clog2(n + 1) + 1;
  endfunction

  function automatic int nbeats(input int n, input int l);
    return (n + l - 1) / l;
  endfunction

endpackage

// File: rtl/tnn_lane_adder.sv
// Combinational signed sum of one beat: each lane adds +x or -x to the total.
module tnn_lane_adder #(
  parameter int LANES = 2,
  parameter int IN_W  = 2,
  parameter int ACC_W = 6
) (
  input  logic [LANES*IN_W-1:0] lane_data,
  input  logic [LANES-1:0]      lane_sign,
  output logic [ACC_W-1:0]      sum
);

  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] total;

  always_comb begin
    total = '0;
    term  = '0;
    for (int i = 0; i < LANES; i++) begin
      term            = '0;
      term[IN_W-1:0]  = lane_data[i*IN_W +: IN_W];
      if (lane_sign[i]) total = total + term;
      else              total = total - term;
    end
  end

  assign sum = total;

endmodule

// File: rtl/tnn_seq_neuron.sv
// Multi-cycle ternary-weight neuron: accumulates LANES signed terms per beat and
// emits a 1-bit decision (sum > threshold) on a valid/ready output port.
module tnn_seq_neuron
  import tnn_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int IN_W  = 2,
  parameter int LANES = 2,
  parameter int ACC_W = acc_width(N_IN, IN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic [N_IN-1:0]      sign_mask,
  input  logic [ACC_W-1:0]     threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_bit,
  output logic                 busy
);

  localparam int NBEATS = nbeats(N_IN, LANES);
  localparam int BEAT_W = $clog2(NBEATS + 1);
  localparam int LW     = LANES * IN_W;
  localparam int PAD_W  = NBEATS * LW;
  localparam int PAD_M  = NBEATS * LANES;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ACCUM = S_ACCUM;
  localparam logic [1:0] ST_DONE  = S_DONE;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS);

  logic [1:0]              state;
  logic [BEAT_W-1:0]       beat;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thr_q;
  logic [N_IN*IN_W-1:0]    data_q;
  logic [N_IN-1:0]         mask_q;

  logic [PAD_W-1:0]        data_pad;
  logic [PAD_M-1:0]        mask_pad;
  logic [LW-1:0]           lane_data;
  logic [LANES-1:0]        lane_sign;
  logic [ACC_W-1:0]        beat_sum;
  logic                    accept;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is also high in DONE while out_ready is high, so a new vector can
  // be taken in the same cycle the decision is consumed.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ACCUM) || (state == ST_DONE);

  // Channels beyond N_IN are zero, so they add -0 whatever their mask bit.
  assign data_pad = PAD_W'(data_q);
  assign mask_pad = PAD_M'(mask_q);

  always_comb begin
    lane_data = '0;
    lane_sign = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        lane_data = data_pad[b*LW +: LW];
        lane_sign = mask_pad[b*LANES +: LANES];
      end
    end
  end

  tnn_lane_adder #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_lane_adder (
    .lane_data (lane_data),
    .lane_sign (lane_sign),
    .sum       (beat_sum)
  );

  // beat runs 0..NBEATS; the extra step registers the comparison so the
  // decision appears NBEATS+1 cycles after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      beat    <= '0;
      acc     <= '0;
      out_bit <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      thr_q   <= '0;
    end else if (accept) begin
      data_q <= in_data;
      mask_q <= sign_mask;
      thr_q  <= threshold;
      acc    <= '0;
      beat   <= '0;
      state  <= ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (beat == LAST_BEAT) begin
            out_bit <= (acc > thr_q);
            state   <= ST_DONE;
          end else begin
            acc  <= acc + $signed(beat_sum);
            beat <= beat + BEAT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_seq_neuron.sv
// Bench for tnn_seq_neuron: a 2-lane and a 4-lane instance, table vectors,
// hand-written handshake/reset sequences and randomized vectors against a model.
module tb_tnn_seq_neuron;
  import tnn_pkg::*;

  localparam int N_IN  = 6;
  localparam int IN_W  = 2;
  localparam int ACC_W = acc_width(N_IN, IN_W);
  localparam int DW    = N_IN * IN_W;

  typedef struct {
    logic [DW-1:0]           data;
    logic [N_IN-1:0]         mask;
    logic signed [ACC_W-1:0] thr;
    logic                    exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]              in_valid;
  logic [1:0]              in_ready;
  logic [1:0]              out_valid;
  logic [1:0]              out_ready;
  logic [1:0]              out_bit;
  logic [1:0]              busy;
  logic [DW-1:0]           in_data   [2];
  logic [N_IN-1:0]         sign_mask [2];
  logic signed [ACC_W-1:0] threshold [2];

  int passed = 0;
  int total  = 0;
  logic [0:0] exp_q[$];
  vec_t tbl[7];

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  tnn_seq_neuron #(.N_IN(N_IN), .IN_W(IN_W), .LANES(2)) u_dut_l2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .sign_mask (sign_mask[0]),
    .threshold (threshold[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_bit   (out_bit[0]),
    .busy      (busy[0])
  );

  tnn_seq_neuron #(.N_IN(N_IN), .IN_W(IN_W), .LANES(4)) u_dut_l4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .sign_mask (sign_mask[1]),
    .threshold (threshold[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_bit   (out_bit[1]),
    .busy      (busy[1])
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain signed integer sum of +/-x_k, strict compare with threshold.
  function automatic logic model(input logic [DW-1:0] data, input logic [N_IN-1:0] mask,
                                 input logic signed [ACC_W-1:0] thr);
    int sum;
    int x;
    sum = 0;
    for (int k = 0; k < N_IN; k++) begin
      x = int'(data[k*IN_W +: IN_W]);
      if (mask[k]) sum += x;
      else         sum -= x;
    end
    return sum > int'(thr);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the selected DUT idle.
  task automatic run_vec(input int sel, input logic [DW-1:0] data, input logic [N_IN-1:0] mask,
                         input logic signed [ACC_W-1:0] thr, input logic exp, input int exp_lat,
                         input int hold, input string name);
    int k;
    check({name, "_in_ready"}, int'(in_ready[sel]), 1);
    in_data[sel]   = data;
    sign_mask[sel] = mask;
    threshold[sel] = thr;
    in_valid[sel]  = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid[sel]  = 1'b0;
    in_data[sel]   = DW'($urandom);
    sign_mask[sel] = N_IN'($urandom);
    threshold[sel] = ACC_W'($urandom);
    k = 0;
    while (out_valid[sel] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_lat);
    repeat (hold) @(negedge clk);
    check({name, "_valid_held"}, int'(out_valid[sel]), 1);
    check({name, "_out_bit"}, int'(out_bit[sel]), int'(exp_q.pop_front()));
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check({name, "_released"}, int'(out_valid[sel]), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    logic seen;
    logic [DW-1:0] rd;
    logic [N_IN-1:0] rm;
    logic signed [ACC_W-1:0] rt;
    int t;

    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      in_data[s]   = '0;
      sign_mask[s] = '0;
      threshold[s] = '0;
    end

    tbl[0] = '{12'h033, 6'b000101, ACC_W'(0),   1'b1};
    tbl[1] = '{12'h055, 6'b000101, ACC_W'(0),   1'b0};
    tbl[2] = '{12'hFFF, 6'b000000, ACC_W'(-18), 1'b0};
    tbl[3] = '{12'hFFF, 6'b000000, ACC_W'(-19), 1'b1};
    tbl[4] = '{12'hFFF, 6'b111111, ACC_W'(17),  1'b1};
    tbl[5] = '{12'hFFF, 6'b111111, ACC_W'(18),  1'b0};
    tbl[6] = '{12'h0C3, 6'b001000, ACC_W'(-1),  1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_out_valid", int'(out_valid[s]), 0);
      check("reset_busy", int'(busy[s]), 0);
      check("reset_out_bit", int'(out_bit[s]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) check("post_reset_in_ready", int'(in_ready[s]), 1);

    // Table vectors on the 2-lane instance
    for (int i = 0; i < 7; i++)
      run_vec(0, tbl[i].data, tbl[i].mask, tbl[i].thr, tbl[i].exp, 4, i % 3, $sformatf("tbl%0d", i));

    // Backpressure in DONE, then back-to-back acceptance
    in_data[0] = 12'h033; sign_mask[0] = 6'b000101; threshold[0] = '0; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    k = 0;
    while (out_valid[0] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_latency", k, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1; in_data[0] = 12'hFFF; sign_mask[0] = '0; threshold[0] = ACC_W'(-32);
      check("bp_out_valid", int'(out_valid[0]), 1);
      check("bp_out_bit", int'(out_bit[0]), 1);
      check("bp_in_ready", int'(in_ready[0]), 0);
      @(negedge clk);
    end
    in_data[0] = 12'h055; sign_mask[0] = 6'b000101; threshold[0] = '0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", int'(in_ready[0]), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    check("b2b_out_valid_drop", int'(out_valid[0]), 0);
    check("b2b_busy", int'(busy[0]), 1);
    k = 0;
    while (out_valid[0] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_latency", k, 4);
    check("b2b_out_bit", int'(out_bit[0]), 0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset during the second accumulation beat
    in_data[0] = 12'h033; sign_mask[0] = 6'b000101; threshold[0] = '0; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready[0]), 1);
    check("midrst_busy_after", int'(busy[0]), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_stale", int'(seen), 0);
    run_vec(0, 12'h0C3, 6'b000001, ACC_W'(0), 1'b0, 4, 0, "midrst_recover");

    // 4-lane instance: padded lanes must contribute nothing
    run_vec(1, 12'h033, 6'b000101, ACC_W'(0), 1'b1, 3, 1, "l4_t1");
    run_vec(1, 12'hFFF, 6'b000000, ACC_W'(-19), 1'b1, 3, 0, "l4_min");

    // Randomized vectors against the model
    for (int i = 0; i < 40; i++) begin
      rd = DW'($urandom);
      rm = N_IN'($urandom);
      t  = int'($urandom_range(0, 40)) - 20;
      rt = ACC_W'(t);
      run_vec(0, rd, rm, rt, model(rd, rm, rt), 4, int'($urandom_range(0, 3)), "rand_l2");
    end
    for (int i = 0; i < 15; i++) begin
      rd = DW'($urandom);
      rm = N_IN'($urandom);
      t  = int'($urandom_range(0, 40)) - 20;
      rt = ACC_W'(t);
      run_vec(1, rd, rm, rt, model(rd, rm, rt), 3, int'($urandom_range(0, 3)), "rand_l4");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
